// File: rtl/everloop_pkg.sv
// Shared types and defaults for the WS281x-style LED ring serializer.
package everloop_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } everloop_state_e;

  localparam int DEF_N_LEDS   = 35;
  localparam int DEF_BPL      = 3;
  localparam int DEF_TBIT_CYC = 63;
  localparam int DEF_T0H_CYC  = 20;
  localparam int DEF_T1H_CYC  = 40;
  localparam int DEF_TRST_CYC = 2500;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((64'(1) << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/everloop_bit_tx.sv
// One-bit waveform generator: high for T1H/T0H cycles, then low until TBIT.
module everloop_bit_tx
  import everloop_pkg::*;
#(
  parameter int TBIT_CYC = DEF_TBIT_CYC,
  parameter int T0H_CYC  = DEF_T0H_CYC,
  parameter int T1H_CYC  = DEF_T1H_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic tx_bit,
  output logic line,
  output logic bit_end
);

  localparam int CW = (clog2(TBIT_CYC) < 1) ? 1 : clog2(TBIT_CYC);

  logic [CW-1:0] cnt;
  logic          cur;
  logic          act;

  // A load on the bit_end cycle chains the next bit with no idle gap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      cur <= 1'b0;
      act <= 1'b0;
    end else if (load) begin
      cnt <= '0;
      cur <= tx_bit;
      act <= 1'b1;
    end else if (act) begin
      if (bit_end) begin
        cnt <= '0;
        act <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bit_end = act && (cnt == CW'(TBIT_CYC - 1));
  assign line    = act && (cnt < (cur ? CW'(T1H_CYC) : CW'(T0H_CYC)));

endmodule

// File: rtl/everloop_gen.sv
// LED ring frame engine: walks the pixel RAM, serializes each byte MSB first,
// then holds the line low for the latch interval.
module everloop_gen
  import everloop_pkg::*;
#(
  parameter int N_LEDS   = DEF_N_LEDS,
  parameter int BPL      = DEF_BPL,
  parameter int TBIT_CYC = DEF_TBIT_CYC,
  parameter int T0H_CYC  = DEF_T0H_CYC,
  parameter int T1H_CYC  = DEF_T1H_CYC,
  parameter int TRST_CYC = DEF_TRST_CYC,
  localparam int NBYTES  = N_LEDS * BPL,
  localparam int AW      = (clog2(NBYTES) < 1) ? 1 : clog2(NBYTES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          cont,
  input  logic [2:0]    bright,
  input  logic [7:0]    data_RGB,
  output logic [AW-1:0] address,
  output logic          everloop_d,
  output logic          busy,
  output logic          done
);

  localparam int LW = (clog2(TRST_CYC) < 1) ? 1 : clog2(TRST_CYC);

  if (!(T0H_CYC < T1H_CYC && T1H_CYC < TBIT_CYC) || !(BPL == 3 || BPL == 4)) begin : g_bad_params
    $error("everloop_gen: illegal timing or BPL parameters");
  end

  everloop_state_e state, nxt;
  logic [7:0]    sreg;
  logic [2:0]    bit_idx;
  logic [AW-1:0] byte_idx;
  logic [LW-1:0] lcnt;
  logic [7:0]    fetched;
  logic          bit_end, last_bit, last_byte, latch_end;
  logic          byte_load, bit_load, tx_load, tx_bit;

  assign fetched   = data_RGB >> bright;
  assign last_bit  = (bit_idx == 3'd7);
  assign last_byte = (byte_idx == AW'(NBYTES - 1));
  assign latch_end = (state == LATCH) && (lcnt == LW'(TRST_CYC - 1));

  // Address 0 is held in IDLE/LATCH, so byte 0 is already valid in FETCH.
  assign byte_load = (state == FETCH) ||
                     ((state == SHIFT) && bit_end && last_bit && !last_byte);
  assign bit_load  = (state == SHIFT) && bit_end && !last_bit;
  assign tx_load   = byte_load || bit_load;
  assign tx_bit    = byte_load ? fetched[7] : sreg[6];

  everloop_bit_tx #(
    .TBIT_CYC(TBIT_CYC),
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC)
  ) u_bit_tx (
    .clk    (clk),
    .rst    (rst),
    .load   (tx_load),
    .tx_bit (tx_bit),
    .line   (everloop_d),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      sreg     <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      lcnt     <= '0;
    end else begin
      state <= nxt;
      if (byte_load) begin
        sreg     <= fetched;
        bit_idx  <= '0;
        byte_idx <= (state == FETCH) ? '0 : byte_idx + 1'b1;
      end else if (bit_load) begin
        sreg    <= {sreg[6:0], 1'b0};
        bit_idx <= bit_idx + 1'b1;
      end else if ((state == SHIFT) && bit_end) begin
        bit_idx  <= '0;
        byte_idx <= '0;
      end
      if (state == LATCH) lcnt <= latch_end ? '0 : lcnt + 1'b1;
      else                lcnt <= '0;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (start || cont) nxt = FETCH;
      FETCH: nxt = SHIFT;
      SHIFT: if (bit_end && last_bit && last_byte) nxt = LATCH;
      LATCH: if (latch_end) nxt = cont ? FETCH : IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Prefetch: the last bit of a byte presents the next address (0 after the final byte).
  always_comb begin
    address = '0;
    if (state == SHIFT) begin
      if (last_bit) address = last_byte ? '0 : byte_idx + 1'b1;
      else          address = byte_idx;
    end
  end

  assign busy = (state != IDLE);
  assign done = latch_end;

endmodule

// File: tb/tb_everloop_gen.sv
// Cycle-accurate waveform/address check of everloop_gen against a per-cycle
// expectation built from the frame timing rules.
module tb_everloop_gen;

  localparam int N_LEDS = 2, BPL = 3, TBIT = 10, T0H = 3, T1H = 7, TRST = 20;
  localparam int NB = N_LEDS * BPL;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, cont;
  logic [2:0]    bright;
  logic [7:0]    data_RGB;
  logic [AW-1:0] address;
  logic          everloop_d, busy, done;

  logic [7:0]    ram [8];
  logic [AW+2:0] exp_q [$];
  int            n_assert = 0;
  int            n_fail   = 0;

  everloop_gen #(
    .N_LEDS(N_LEDS), .BPL(BPL), .TBIT_CYC(TBIT),
    .T0H_CYC(T0H), .T1H_CYC(T1H), .TRST_CYC(TRST)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .bright(bright),
    .data_RGB(data_RGB), .address(address), .everloop_d(everloop_d),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous-read pixel RAM: data follows the address by one cycle.
  always @(posedge clk) data_RGB <= ram[address];

  // Expected {address, line, busy, done} for every cycle of one frame, from the
  // FETCH cycle through the last latch cycle. Byte i is loaded on the edge that
  // ends cycle TBIT*8*i; bright changed before that edge (cycle index sw) applies.
  task automatic push_frame(input int br0, input int br1, input int sw);
    logic [7:0] v;
    int h, a;
    exp_q.push_back({3'd0, 1'b0, 1'b1, 1'b0});
    for (int i = 0; i < NB; i++) begin
      v = ram[i] >> ((TBIT * 8 * i >= sw) ? br1 : br0);
      for (int k = 0; k < 8; k++) begin
        h = v[7-k] ? T1H : T0H;
        a = (k == 7) ? ((i == NB - 1) ? 0 : i + 1) : i;
        for (int c = 0; c < TBIT; c++)
          exp_q.push_back({3'(a), (c < h), 1'b1, 1'b0});
      end
    end
    for (int c = 0; c < TRST; c++)
      exp_q.push_back({3'd0, 1'b0, 1'b1, (c == TRST - 1)});
  endtask

  task automatic push_idle(input int n);
    for (int c = 0; c < n; c++) exp_q.push_back('0);
  endtask

  task automatic check_cycles(input string tag, input int n);
    logic [AW+2:0] e, o;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      o = {address, everloop_d, busy, done};
      n_assert++;
      assert (o === e) else begin
        n_fail++;
        $error("FAIL %s cyc=%0d observed{addr,d,busy,done}=%b required=%b", tag, j, o, e);
      end
    end
  endtask

  task automatic check_now(input string tag, input logic [AW+2:0] e);
    logic [AW+2:0] o;
    o = {address, everloop_d, busy, done};
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed{addr,d,busy,done}=%b required=%b", tag, o, e);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic rand_ram();
    for (int i = 0; i < 8; i++) ram[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; cont = 1'b0; bright = 3'd0;
    for (int i = 0; i < 8; i++) ram[i] = 8'hAA;
    #3 check_now("reset_state", '0);
    repeat (3) @(negedge clk);
    check_now("reset_held", '0);
    rst = 1'b1;

    // All 0xAA: alternating 7/3 and 3/7 bits, busy for FETCH+bits+latch, one done.
    pulse_start();
    push_frame(0, 0, 1 << 30); push_idle(5);
    check_cycles("frame_aa", exp_q.size());

    // Byte 0 = 0x80 with bright 1 goes out as 0x40.
    rand_ram(); ram[0] = 8'h80; bright = 3'd1;
    pulse_start();
    push_frame(1, 1, 1 << 30); push_idle(3);
    check_cycles("bright1", exp_q.size());

    // Random data and brightness, including the 0x00-only shifts near 7.
    for (int r = 0; r < 3; r++) begin
      rand_ram(); bright = 3'($urandom_range(0, 7));
      pulse_start();
      push_frame(int'(bright), int'(bright), 1 << 30); push_idle(2);
      check_cycles("rand_frame", exp_q.size());
    end

    // Brightness changed mid-frame applies from the next byte load.
    rand_ram(); bright = 3'd0;
    pulse_start();
    push_frame(0, 3, 124); push_idle(2);
    check_cycles("bright_mid_a", 125);
    bright = 3'd3;
    check_cycles("bright_mid_b", exp_q.size());
    bright = 3'd0;

    // Continuous mode: back-to-back frames, cont dropped during the second one.
    rand_ram();
    @(posedge clk); #1 cont = 1'b1;
    @(posedge clk); #1;
    push_frame(0, 0, 1 << 30); push_frame(0, 0, 1 << 30); push_idle(5);
    check_cycles("cont_a", 600);
    cont = 1'b0;
    check_cycles("cont_b", exp_q.size());

    // start re-asserted while busy is ignored.
    rand_ram();
    pulse_start();
    push_frame(0, 0, 1 << 30); push_idle(30);
    check_cycles("restart_a", 50);
    start = 1'b1;
    check_cycles("restart_b", 30);
    start = 1'b0;
    check_cycles("restart_c", exp_q.size());

    // Reset mid-frame aborts at once; a new start begins again at byte 0.
    rand_ram();
    pulse_start();
    push_frame(0, 0, 1 << 30);
    check_cycles("abort_pre", 100);
    rst = 1'b0;
    #1 check_now("abort_rst", '0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    push_idle(3);
    check_cycles("abort_idle", 3);
    pulse_start();
    push_frame(0, 0, 1 << 30); push_idle(3);
    check_cycles("abort_new", exp_q.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
